// File: rtl/bcd_serial_add_ctrl.sv
// Serial BCD adder sequencer: validates NDIG-digit operands, then adds one digit per clock LSD first.
// Optional BCD_SAT_EN: a final decimal carry saturates the result to all-9s.
module bcd_serial_add_ctrl #(
  parameter int NDIG = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [4*NDIG-1:0] a,
  input  logic [4*NDIG-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [4*NDIG-1:0] result,
  output logic            carry_out,
  output logic            err
);
  localparam int W  = 4*NDIG;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, CHECK, ADD, DONE} state_t;

  state_t        state;
  logic [W-1:0]  a_q, b_q;
  logic [IW-1:0] idx;
  logic          cy;

  logic [3:0] a_d, b_d, dig;
  logic [4:0] s, s6;
  logic       c_nxt, bad, last;

  // Shared digit adder: binary sum plus 6-correction above 9
  always_comb begin
    a_d   = a_q[{idx, 2'b00} +: 4];
    b_d   = b_q[{idx, 2'b00} +: 4];
    s     = {1'b0, a_d} + {1'b0, b_d} + {4'b0, cy};
    s6    = s + 5'd6;
    c_nxt = (s > 5'd9);
    dig   = c_nxt ? s6[3:0] : s[3:0];
    last  = (idx == IW'(NDIG-1));
  end

  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < NDIG; i++)
      if (a_q[4*i +: 4] > 4'd9 || b_q[4*i +: 4] > 4'd9) bad = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      idx       <= '0;
      cy        <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          a_q       <= a;
          b_q       <= b;
          result    <= '0;
          carry_out <= 1'b0;
          err       <= 1'b0;
          cy        <= 1'b0;
          idx       <= '0;
          busy      <= 1'b1;
          state     <= CHECK;
        end
        CHECK: if (bad) begin
          err       <= 1'b1;
          result    <= '0;
          carry_out <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b1;
          state     <= DONE;
        end else begin
          idx   <= '0;
          state <= ADD;
        end
        ADD: begin
          result[{idx, 2'b00} +: 4] <= dig;
          cy <= c_nxt;
          if (last) begin
            carry_out <= c_nxt;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
`ifdef BCD_SAT_EN
            if (c_nxt) result <= {NDIG{4'h9}};
`endif
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
